// File: rtl/rv_multicycle_sequencer_if.sv
// rv_multicycle_sequencer_if
//   Bundles the sequencer's control inputs and its strobes/status outputs.
//   slave  : the sequencer (consumes run/decoder/memory-ready, drives strobes)
//   master : the surrounding datapath / memory system
//   Signals:
//     run, opcode[6:0], we_mem_dec, we_reg_dec, imem_ready, dmem_ready  (to sequencer)
//     imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, busy, trap,
//     trap_cause[1:0]                                                  (from sequencer)
interface rv_multicycle_sequencer_if;
  logic       run;
  logic [6:0] opcode;
  logic       we_mem_dec;
  logic       we_reg_dec;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       ir_load;
  logic       dmem_req;
  logic       dmem_we;
  logic       rf_we;
  logic       pc_en;
  logic       busy;
  logic       trap;
  logic [1:0] trap_cause;

  modport slave (
    input  run, opcode, we_mem_dec, we_reg_dec, imem_ready, dmem_ready,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, busy, trap, trap_cause
  );

  modport master (
    output run, opcode, we_mem_dec, we_reg_dec, imem_ready, dmem_ready,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, busy, trap, trap_cause
  );
endinterface

// File: rtl/rv_multicycle_sequencer.sv
// rv_multicycle_sequencer
//   Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue RISC-V
//   datapath. Gates decoder write enables so the register file and data memory
//   are written at most once per instruction; traps on illegal opcodes and on
//   instruction/data memory timeouts (trap is sticky until rst).
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : rv_multicycle_sequencer_if.slave (run, decoder, memory handshakes,
//            strobes, busy/trap status)
//     retired_cnt/stall_cnt : 32-bit performance counters, present only when
//            the macro SEQ_PERF_CNT_EN is defined
//   Parameters:
//     MEM_TIMEOUT  : wait cycles tolerated on imem_ready/dmem_ready before trap
//     RESET_HALTED : 1 = after reset, stay in IDLE until run is seen low then high
module rv_multicycle_sequencer #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  rv_multicycle_sequencer_if.slave bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cause_nxt;
  logic             armed;
  logic             go;

  logic             imem_req_p1, dmem_req_p1, dmem_we_p1;
  logic             rf_we_p1, pc_wb_p1, busy_p1, trap_p1;
  logic [1:0]       cause_p1;
  logic             store_done;
  logic             ir_load_c;
  logic             pc_en_c;

  // With RESET_HALTED the sequencer needs a fresh run assertion after reset.
  assign go = bus.run && (!RESET_HALTED || armed);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (state == S_IDLE && !bus.run) begin
      armed <= 1'b1;
    end
  end

  // ---- stage p0: next-state decode ----
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    cause_nxt = cause_p1;
    unique case (state)
      S_IDLE: begin
        if (go) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A ready in the final allowed wait cycle still counts as success.
        if (bus.imem_ready) begin
          state_nxt = S_DECODE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_legal(bus.opcode)) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b01;
        end
      end
      S_EXEC: begin
        state_nxt = is_mem(bus.opcode) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (bus.opcode == OP_LOAD) state_nxt = S_WB;
          else                       state_nxt = bus.run ? S_FETCH : S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b11;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        state_nxt = bus.run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- stage p1: state and Moore outputs registered from next state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cause_p1    <= 2'b00;
      imem_req_p1 <= 1'b0;
      dmem_req_p1 <= 1'b0;
      dmem_we_p1  <= 1'b0;
      rf_we_p1    <= 1'b0;
      pc_wb_p1    <= 1'b0;
      busy_p1     <= 1'b0;
      trap_p1     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cause_p1    <= cause_nxt;
      imem_req_p1 <= (state_nxt == S_FETCH);
      dmem_req_p1 <= (state_nxt == S_MEM);
      dmem_we_p1  <= (state_nxt == S_MEM) && bus.we_mem_dec;
      rf_we_p1    <= (state_nxt == S_WB) && bus.we_reg_dec;
      pc_wb_p1    <= (state_nxt == S_WB);
      busy_p1     <= (state_nxt != S_IDLE) && (state_nxt != S_TRAP);
      trap_p1     <= (state_nxt == S_TRAP);
    end
  end

  // Handshake-completion strobes must land in the ready cycle itself.
  assign ir_load_c  = (state == S_FETCH) && bus.imem_ready;
  assign store_done = (state == S_MEM) && bus.dmem_ready && (bus.opcode == OP_STORE);
  assign pc_en_c    = pc_wb_p1 || store_done;

  assign bus.imem_req   = imem_req_p1;
  assign bus.ir_load    = ir_load_c;
  assign bus.dmem_req   = dmem_req_p1;
  assign bus.dmem_we    = dmem_we_p1;
  assign bus.rf_we      = rf_we_p1;
  assign bus.pc_en      = pc_en_c;
  assign bus.busy       = busy_p1;
  assign bus.trap       = trap_p1;
  assign bus.trap_cause = cause_p1;

`ifdef SEQ_PERF_CNT_EN
  // Both counters stop naturally in TRAP: no pc_en and no FETCH/MEM cycles there.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (pc_en_c) retired_cnt <= retired_cnt + 32'd1;
      if ((state == S_FETCH && !bus.imem_ready) || (state == S_MEM && !bus.dmem_ready))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
